// File: rtl/direct_corr_buffer_pkg.sv
// Shared configuration for the correspondence buffer path.
// Field widths, buffer depth, entry struct and state encoding.
package RgbdVoConfigPk;

  localparam int CORR_FIFO_DEPTH = 16;
  localparam int CORR_CNT_BW     = 19;

  localparam int DATA_DEPTH_BW   = 16;
  localparam int CLOUD_BW        = 24;
  localparam int H_SIZE_BW       = 10;
  localparam int V_SIZE_BW       = 10;

  typedef struct packed {
    logic [DATA_DEPTH_BW-1:0] depth0;
    logic [CLOUD_BW-1:0]      trans_z1;
    logic [H_SIZE_BW-1:0]     idx0_x;
    logic [V_SIZE_BW-1:0]     idx0_y;
    logic [H_SIZE_BW-1:0]     idx1_x;
    logic [V_SIZE_BW-1:0]     idx1_y;
  } corr_t;

  localparam int CORR_W = $bits(corr_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } buf_state_e;

  // Saturating increment for the per-frame counter.
  function automatic logic [CORR_CNT_BW-1:0] cnt_sat_inc(
    input logic [CORR_CNT_BW-1:0] v
  );
    logic [CORR_CNT_BW-1:0] r;
    r = v;
    if (v != {CORR_CNT_BW{1'b1}}) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/direct_corr_buffer_fifo.sv
// corr_sync_fifo: synchronous FIFO, power-of-2 depth.
// Head is shown combinationally; the last popped word is held when empty.
module corr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == DEPTH_C);
  assign o_empty = (cnt_q == '0);

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  assign o_data = o_empty ? last_q : mem_q[rptr_q];

  // Next pointers, occupancy and held output word.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (do_push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
      last_d = mem_q[rptr_q];
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  // Storage array; contents are only read while occupied.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= i_data;
    end
  end

endmodule

// File: rtl/direct_corr_buffer.sv
// direct_corr_buffer: frame-aware correspondence FIFO.
// Optional per-frame counter built when DIRECT_CORR_CNT_EN is defined.
module direct_corr_buffer
  import RgbdVoConfigPk::*;
#(
  parameter int FIFO_DEPTH = CORR_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic                     i_frame_end,
  input  logic                     i_valid,
  input  logic [DATA_DEPTH_BW-1:0] i_depth0,
  input  logic [CLOUD_BW-1:0]      i_trans_z1,
  input  logic [H_SIZE_BW-1:0]     i_idx0_x,
  input  logic [V_SIZE_BW-1:0]     i_idx0_y,
  input  logic [H_SIZE_BW-1:0]     i_idx1_x,
  input  logic [V_SIZE_BW-1:0]     i_idx1_y,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_DEPTH_BW-1:0] o_depth0,
  output logic [CLOUD_BW-1:0]      o_trans_z1,
  output logic [H_SIZE_BW-1:0]     o_idx0_x,
  output logic [V_SIZE_BW-1:0]     o_idx0_y,
  output logic [H_SIZE_BW-1:0]     o_idx1_x,
  output logic [V_SIZE_BW-1:0]     o_idx1_y,
  output logic                     o_frame_done,
  output logic [CORR_CNT_BW-1:0]   o_corr_cnt,
  output logic                     o_overflow
);

  buf_state_e state_q, state_d;
  logic       frame_done_q;
  logic       overflow_q, overflow_d;

  corr_t      in_c;
  corr_t      head_c;
  logic       fifo_full;
  logic       fifo_empty;
  logic       win;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       drop;

  assign in_c.depth0   = i_depth0;
  assign in_c.trans_z1 = i_trans_z1;
  assign in_c.idx0_x   = i_idx0_x;
  assign in_c.idx0_y   = i_idx0_y;
  assign in_c.idx1_x   = i_idx1_x;
  assign in_c.idx1_y   = i_idx1_y;

  // Input is only taken inside a frame or on a marker cycle.
  assign win      = (state_q == ST_ACTIVE)
                  || i_frame_start
                  || i_frame_end;
  assign push_req = i_valid && win;
  assign pop      = !fifo_empty && i_ready;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && !push;

  corr_sync_fifo #(
    .WIDTH (CORR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (in_c),
    .i_pop   (pop),
    .o_data  (head_c),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_valid    = !fifo_empty;
  assign o_depth0   = head_c.depth0;
  assign o_trans_z1 = head_c.trans_z1;
  assign o_idx0_x   = head_c.idx0_x;
  assign o_idx0_y   = head_c.idx0_y;
  assign o_idx1_x   = head_c.idx1_x;
  assign o_idx1_y   = head_c.idx1_y;

  // Frame sequencing; start wins over everything, start+end goes to drain.
  always_comb begin
    state_d = state_q;
    if (i_frame_start && i_frame_end) begin
      state_d = ST_DRAIN;
    end else if (i_frame_start) begin
      state_d = ST_ACTIVE;
    end else if (state_q == ST_ACTIVE && i_frame_end) begin
      state_d = ST_DRAIN;
    end else if (state_q == ST_DRAIN && fifo_empty && !push) begin
      state_d = ST_IDLE;
    end
  end

  // Sticky drop flag, restarted by each frame start.
  always_comb begin
    overflow_d = overflow_q | drop;
    if (i_frame_start) begin
      overflow_d = drop;
    end
  end

  // State register with registered done pulse and overflow flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == ST_DRAIN)
                   && (state_d == ST_IDLE);
      overflow_q   <= overflow_d;
    end
  end

  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;

`ifdef DIRECT_CORR_CNT_EN
  logic [CORR_CNT_BW-1:0] cnt_q, cnt_d;

  // Accepted-entry count; a push on the start cycle counts after the clear.
  always_comb begin
    cnt_d = cnt_q;
    if (i_frame_start) begin
      cnt_d = {{(CORR_CNT_BW-1){1'b0}}, push};
    end else if (push) begin
      cnt_d = cnt_sat_inc(cnt_q);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_corr_cnt = cnt_q;
`else
  assign o_corr_cnt = '0;
`endif

endmodule
